// File: rtl/diffusion_pkg.sv
`default_nettype none
// ============================================================================
// Module   : diffusion_pkg
// Purpose  : Shared definitions for the diffusion banked-BRAM requester and
//            its scheduler/conflict partners: default widths, the parking
//            address pattern and the requester FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package diffusion_pkg;

  // Default global word-address and data widths, shared with the scheduler.
  localparam int DIFF_ADDR_WIDTH = 13;
  localparam int DIFF_DATA_WIDTH = 32;

  // Parking address pattern: all ones, truncated to the address width in use.
  // It must lie outside every bank range so an idle lane is never selected.
  localparam logic [63:0] DIFF_PARK_ALL_ONES = '1;

  // Requester FSM encoding: 3 bits, 7 states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_CHK  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_ACC     = 3'd4,
    ST_WR_REQ  = 3'd5,
    ST_WR_CHK  = 3'd6
  } req_state_t;

endpackage
`default_nettype wire

// File: rtl/diffusion_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : diffusion_sat_counter
// Purpose  : Saturating up-counter with synchronous clear; holds at all ones.
// Revision : 1.0 - initial release
// ============================================================================
module diffusion_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  // Count increments until the all-ones value, then holds.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/diffusion_bank_requester.sv
`default_nettype none
// ============================================================================
// Module   : diffusion_bank_requester
// Purpose  : Per-lane requester for the banked-BRAM scheduler. Accepts one
//            read-modify-write operation at a time, issues the read beat,
//            accumulates the delta and issues the write beat, re-sending any
//            beat that lost arbitration so each operation retires once.
// Options  : DIFFUSION_REQ_STATS_EN adds saturating retry_cnt / op_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module diffusion_bank_requester
  import diffusion_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DIFF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DIFF_DATA_WIDTH,
  parameter int                    RD_LAT     = 1,
  parameter logic [ADDR_WIDTH-1:0] PARK_ADDR  = ADDR_WIDTH'(DIFF_PARK_ALL_ONES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [ADDR_WIDTH-1:0] op_addr,
  input  logic [DATA_WIDTH-1:0] op_delta,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  conflict_in,
  output logic                  busy,
`ifdef DIFFUSION_REQ_STATS_EN
  output logic [15:0]           retry_cnt,
  output logic [15:0]           op_cnt,
`endif
  output logic                  done
);

  // Read-latency counter start value; RD_LAT is limited to 1..4.
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  req_state_t            state;
  req_state_t            state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] delta_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic [1:0]            lat_cnt;
  logic                  retry;

  // State register plus operation capture, latency count and accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      delta_q <= '0;
      sum_q   <= '0;
      lat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (op_valid && op_ready) begin
        addr_q  <= op_addr;
        delta_q <= op_delta;
      end
      if (state == ST_RD_CHK) begin
        lat_cnt <= LAT_INIT;
      end else if (state == ST_RD_WAIT) begin
        lat_cnt <= lat_cnt - 2'd1;
      end
      // Sum is registered once; a write retry resends it unchanged.
      if (state == ST_ACC) begin
        sum_q <= data_in + delta_q;
      end
    end
  end

  // Next-state and beat outputs; the lane parks whenever no beat is owned.
  always_comb begin
    state_nxt = state;
    addr_out  = PARK_ADDR;
    data_out  = '0;
    write_en  = 1'b0;
    done      = 1'b0;
    retry     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (op_valid) state_nxt = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        addr_out  = addr_q;
        state_nxt = ST_RD_CHK;
      end
      ST_RD_CHK: begin
        addr_out = addr_q;
        if (conflict_in) begin
          retry     = 1'b1;
          state_nxt = ST_RD_REQ;
        end else if (RD_LAT == 1) begin
          state_nxt = ST_ACC;
        end else begin
          state_nxt = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (lat_cnt <= 2'd1) state_nxt = ST_ACC;
      end
      ST_ACC: begin
        state_nxt = ST_WR_REQ;
      end
      ST_WR_REQ: begin
        addr_out  = addr_q;
        data_out  = sum_q;
        write_en  = 1'b1;
        state_nxt = ST_WR_CHK;
      end
      ST_WR_CHK: begin
        addr_out = addr_q;
        data_out = sum_q;
        write_en = 1'b1;
        if (conflict_in) begin
          retry     = 1'b1;
          state_nxt = ST_WR_REQ;
        end else begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign op_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

`ifdef DIFFUSION_REQ_STATS_EN
  diffusion_sat_counter #(.WIDTH(16)) u_retry_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (retry),
    .clear (1'b0),
    .count (retry_cnt)
  );

  diffusion_sat_counter #(.WIDTH(16)) u_op_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (done),
    .clear (1'b0),
    .count (op_cnt)
  );
`else
  logic unused_retry;
  assign unused_retry = retry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_diffusion_bank_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_diffusion_bank_requester
// Purpose  : Self-checking bench for diffusion_bank_requester. A model
//            scheduler owns a small banked memory (addresses 0..31 in range)
//            and injects arbitration conflicts; a scoreboard holds the
//            expected result of every operation and a monitor checks each
//            completed write.
// Options  : DIFFUSION_REQ_STATS_EN also checks retry_cnt / op_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module tb_diffusion_bank_requester;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam logic [AW-1:0] PARK = 13'h1FFF;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] value;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [AW-1:0] op_addr = '0;
  logic [DW-1:0] op_delta = '0;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] data_out;
  logic          write_en;
  logic [DW-1:0] sched_data = '0;
  logic          sched_conf = 1'b0;
  logic          busy;
  logic          done;
`ifdef DIFFUSION_REQ_STATS_EN
  logic [15:0]   retry_cnt;
  logic [15:0]   op_cnt;
`endif

  diffusion_bank_requester dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_addr     (op_addr),
    .op_delta    (op_delta),
    .addr_out    (addr_out),
    .data_out    (data_out),
    .write_en    (write_en),
    .data_in     (sched_data),
    .conflict_in (sched_conf),
    .busy        (busy),
`ifdef DIFFUSION_REQ_STATS_EN
    .retry_cnt   (retry_cnt),
    .op_cnt      (op_cnt),
`endif
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- model scheduler ----------------
  logic [DW-1:0] mem [0:31];
  int  cyc = 0;
  bit  rand_conf = 1'b0;
  int  force_rd = 0;
  int  force_wr = 0;
  int  exp_retries = 0;
  int  rd_beats = 0;
  int  wr_beats = 0;
  bit  beat_even = 1'b1;
  bit  c;

  // A lane owns the port on contiguous in-range cycles that alternate
  // request beat / check beat; conflicts on request beats cause retries.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      sched_conf  <= 1'b0;
      beat_even   = 1'b1;
      exp_retries = 0;
    end else if (addr_out < 32) begin
      c = 1'b0;
      if (beat_even) begin
        if (write_en) wr_beats++; else rd_beats++;
        if (!write_en && force_rd > 0) begin
          c = 1'b1; force_rd--;
        end else if (write_en && force_wr > 0) begin
          c = 1'b1; force_wr--;
        end else if (rand_conf && $urandom_range(0, 9) < 4) begin
          c = 1'b1;
        end
        if (c) exp_retries++;
      end else if (rand_conf && $urandom_range(0, 9) < 3) begin
        c = 1'b1;
      end
      if (!c) begin
        if (write_en) mem[addr_out[4:0]] <= data_out;
        else          sched_data <= mem[addr_out[4:0]];
      end
      sched_conf <= c;
      beat_even  = !beat_even;
    end else begin
      sched_conf <= 1'b0;
      beat_even  = 1'b1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  exp_t exp_q[$];
  logic [DW-1:0] model_mem [0:31];
  int done_cnt = 0;
  int done_since_rst = 0;
  int last_done_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      done_since_rst = 0;
    end else if (done) begin
      done_cnt++;
      done_since_rst++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(addr_out), 64'(e.addr));
        chk("wr_data", 64'(data_out), 64'(e.value));
        chk("mem_after_wr", 64'(mem[e.addr[4:0]]), 64'(e.value));
      end
    end
  end

  // ---------------- stimulus ----------------
  int acc_cyc = 0;
  int pushed = 0;

  // Presents an operation (valid may be held while the lane is busy) and
  // returns after the accepting edge.
  task automatic issue_op(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit push);
    int guard;
    @(negedge clk);
    op_valid = 1'b1;
    op_addr  = a;
    op_delta = d;
    guard = 0;
    while (!op_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) chk("accept_timeout", 64'd1, 64'd0);
    acc_cyc = cyc;
    if (push) begin
      exp_t e;
      model_mem[a[4:0]] = model_mem[a[4:0]] + d;
      e.addr  = a;
      e.value = model_mem[a[4:0]];
      exp_q.push_back(e);
      pushed++;
    end
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int guard = 0;
    while (done_cnt < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) chk("done_timeout", 64'(done_cnt), 64'(target));
    @(negedge clk);
  endtask

  initial begin
    int rb, wb;
    for (int i = 0; i < 32; i++) begin
      mem[i] <= 32'(i * 3);
      model_mem[i] = 32'(i * 3);
    end
    mem[2] <= 32'd7;  model_mem[2] = 32'd7;
    mem[3] <= 32'd10; model_mem[3] = 32'd10;
    mem[4] <= 32'd1;  model_mem[4] = 32'd1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: parked, no beats, ready.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_addr", 64'(addr_out), 64'(PARK));
      chk("idle_we", 64'(write_en), 64'd0);
      chk("idle_ready", 64'(op_ready), 64'd1);
      chk("idle_busy", 64'(busy), 64'd0);
    end
    chk("idle_data", 64'(data_out), 64'd0);
    chk("idle_done", 64'(done), 64'd0);

    // Single op without conflicts: 10 + 5, done five cycles after accept.
    rb = rd_beats; wb = wr_beats;
    issue_op(13'd3, 32'd5, 1'b1);
    wait_done(1);
    chk("done_latency", 64'(last_done_cyc - acc_cyc), 64'd5);
    chk("single_rd_beats", 64'(rd_beats - rb), 64'd1);
    chk("single_wr_beats", 64'(wr_beats - wb), 64'd1);
    chk("mem3", 64'(mem[3]), 64'd15);

    // Two read conflicts, then granted: 7 + 1.
    rb = rd_beats; wb = wr_beats;
    force_rd = 2;
    issue_op(13'd2, 32'd1, 1'b1);
    wait_done(2);
    chk("rdconf_rd_beats", 64'(rd_beats - rb), 64'd3);
    chk("rdconf_wr_beats", 64'(wr_beats - wb), 64'd1);
    chk("mem2", 64'(mem[2]), 64'd8);

    // One write conflict with wrap: 1 + 0xFFFFFFFF = 0, single done.
    rb = rd_beats; wb = wr_beats;
    force_wr = 1;
    issue_op(13'd4, 32'hFFFF_FFFF, 1'b1);
    wait_done(3);
    chk("wrconf_rd_beats", 64'(rd_beats - rb), 64'd1);
    chk("wrconf_wr_beats", 64'(wr_beats - wb), 64'd2);
    chk("mem4", 64'(mem[4]), 64'd0);
    chk("done_count_3", 64'(done_cnt), 64'd3);
`ifdef DIFFUSION_REQ_STATS_EN
    chk("retry_cnt_dir", 64'(retry_cnt), 64'(exp_retries));
    chk("op_cnt_dir", 64'(op_cnt), 64'd3);
`endif

    // Reset while in the first write-request cycle: write is dropped.
    begin
      int guard = 0;
      issue_op(13'd5, 32'd9, 1'b0);
      while (!write_en && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      chk("reach_wr_req", 64'(write_en), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_we", 64'(write_en), 64'd0);
      chk("rst_addr", 64'(addr_out), 64'(PARK));
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem5", 64'(mem[5]), 64'(model_mem[5]));
      rst = 1'b0;
    end

    // Randomized operations with random arbitration losses.
    rand_conf = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue_op(13'($urandom_range(0, 7)), $urandom, 1'b1);
    end
    wait_done(3 + 40);
    rand_conf = 1'b0;
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("done_total", 64'(done_cnt), 64'(pushed));
    chk("final_busy", 64'(busy), 64'd0);
    chk("final_addr", 64'(addr_out), 64'(PARK));
    for (int i = 0; i < 8; i++) begin
      chk("final_mem", 64'(mem[i]), 64'(model_mem[i]));
    end
`ifdef DIFFUSION_REQ_STATS_EN
    chk("retry_cnt_rand", 64'(retry_cnt), 64'(exp_retries));
    chk("op_cnt_rand", 64'(op_cnt), 64'(done_since_rst));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
